// File: rtl/data_mem_responder.sv
// Memory-side responder for CPU data accesses: one load/store per handshake,
// a fixed number of wait states, byte-enable writes and misalign/range errors.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt_p0, cnt_nxt;
  logic        wr_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [3:0]  be_p0;

  logic        accept;
  logic        do_access;
  logic        acc_wr;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        acc_err;
  logic [AW-1:0] acc_idx;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                           input logic [31:0] wd,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_p0;
    req_ready = 1'b0;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_nxt = RESP;
            do_access = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_p0 == 4'd0) begin
          do_access = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt_p0 - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With no wait states the access happens on the accept edge, so it must
  // use the live request inputs rather than the captured copy.
  always_comb begin
    acc_wr    = (state == IDLE) ? req_write : wr_p0;
    acc_addr  = (state == IDLE) ? req_addr  : addr_p0;
    acc_wdata = (state == IDLE) ? req_wdata : wdata_p0;
    acc_be    = (state == IDLE) ? req_be    : be_p0;
    acc_err   = (acc_addr[1:0] != 2'b00) ||
                ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
    acc_idx   = acc_addr[2 +: AW];
  end

  // Stage p0: control state and captured request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt_p0 <= 4'd0;
    end else begin
      state  <= state_nxt;
      cnt_p0 <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_p0    <= 1'b0;
      addr_p0  <= 32'd0;
      wdata_p0 <= 32'd0;
      be_p0    <= 4'd0;
    end else if (accept) begin
      wr_p0    <= req_write;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      be_p0    <= req_be;
    end
  end

  // Stage p1: response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (do_access) begin
      resp_valid <= 1'b1;
      resp_err   <= acc_err;
      resp_rdata <= (!acc_err && !acc_wr) ? mem[acc_idx] : 32'd0;
    end else if (state == RESP && resp_ready) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end
  end

  // Array is not reset; the rst_n gate keeps a store from landing while held in reset.
  always_ff @(posedge clk) begin
    if (rst_n && do_access && acc_wr && !acc_err) begin
      mem[acc_idx] <= merge_be(mem[acc_idx], acc_wdata, acc_be);
    end
  end

endmodule
